mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-high reset
- in_valid  in  1  decode/execute result valid
- in_ready  out  1  stage can accept
- alu_result  in  32  execute result / memory address
- store_data  in  32  rs2 value for stores
- pc_in  in  32  instruction PC
- csr_rdata  in  32  CSR read value
- rd_in  in  5  destination register
- rd_wen_in  in  1  destination write enable
- mem_we  in  1  store
- mem_re  in  1  load
- wb_sel  in  3  {MEM,PC,CSR} one-hot; 0 selects alu_result
- dmem_req  out  1  data-memory request, held until ack
- dmem_we  out  1  request is write
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  request done; dmem_rdata valid this cycle
- dmem_rdata  in  32  load data
- wb_addr  out  5  register write address
- wb_we  out  1  register write pulse
- wb_data  out  32  register write data
- mem_err  out  1  one-cycle error pulse

Function
REQ-003 SHALL implement FSM IDLE, ACCESS; in_ready=1 only in IDLE.
REQ-004 SHALL accept a transfer on in_valid&&in_ready.
REQ-005 Non-memory op accepted in cycle N: SHALL assert wb_we in N+1 (if rd_wen_in and rd_in!=0), stay IDLE, sustain 1 op/cycle.
REQ-006 Writeback data SHALL be chosen by priority: MEM -> dmem_rdata; PC -> pc_in+4 (mod 2^32); CSR -> csr_rdata; none -> alu_result.
REQ-007 Load/store accepted in cycle N: SHALL go to ACCESS and register dmem_req=1, dmem_we=mem_we, dmem_addr=alu_result, dmem_wdata=store_data, visible from N+1.
REQ-008 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable in ACCESS until dmem_ack is sampled high.
REQ-009 On ack in cycle M: dmem_req SHALL drop in M+1 and FSM SHALL return to IDLE; a load SHALL capture dmem_rdata and pulse wb_we in M+1.
REQ-010 Stores SHALL never assert wb_we.
REQ-011 ack in the same cycle req first rises SHALL complete the access (minimum 2-cycle load latency).
REQ-012 dmem_ack outside ACCESS SHALL be ignored.
REQ-013 alu_result[1:0]!=0 on load/store: SHALL not issue a request, SHALL pulse mem_err in N+1, SHALL suppress writeback, stay IDLE.
REQ-014 mem_re&&mem_we both set: SHALL be treated per REQ-013.
REQ-015 wb_we SHALL be a single-cycle pulse, never asserted for rd_in==0; wb_addr and wb_data SHALL be valid whenever wb_we=1.

Reset
REQ-016 rst_n=1 at a clock edge SHALL force IDLE, in_ready=1 in the following cycle, and dmem_req=dmem_we=wb_we=mem_err=0, dmem_addr=dmem_wdata=wb_data=0, wb_addr=0.
REQ-017 Reset during ACCESS SHALL abandon the access: dmem_req=0 next cycle, no writeback, and a late ack SHALL be ignored.

Structure
REQ-018 Shared package riscv_pkg SHALL hold the FSM state enum, WB_SEL bit indices (MEM=2, PC=1, CSR=0), and constants XLEN=32 and REG_ADDR_W=5.
REQ-019 SHALL be a single module with no sub-modules; the writeback mux SHALL be inline.

Verification
REQ-020 ALU op alu_result=0x0000_1234, rd=5, wb_sel=0 -> wb_we=1, wb_addr=5, wb_data=0x1234 in the next cycle.
REQ-021 Load addr=0x100, rd=7, ack after 3 wait cycles with rdata=0xDEAD_BEEF -> dmem_req held 4 cycles with addr stable, then wb_data=0xDEADBEEF to x7; in_ready=0 throughout.
REQ-022 Store addr=0x200, data=0xA5A5_A5A5, immediate ack -> dmem_we=1 for one cycle, no wb_we, in_ready back to 1 after 2 cycles.
REQ-023 Load addr=0x102 -> mem_err pulse, dmem_req never rises, wb_we=0.
REQ-024 Reset asserted during a pending load, then ack arrives -> dmem_req=0 after reset edge, no wb_we; jal-style wb_sel=PC with pc_in=0xFFFF_FFFC, rd=1 -> wb_data=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage.
// Contents:
//   XLEN, REG_ADDR_W   - datapath width and register-address width
//   WB_SEL_*           - bit positions inside the one-hot wb_sel vector
//   mem_state_e        - memory-stage FSM states
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Bit positions in wb_sel; an all-zero wb_sel selects alu_result.
    localparam int WB_SEL_MEM = 2;
    localparam int WB_SEL_PC  = 1;
    localparam int WB_SEL_CSR = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// Memory stage of the pipeline.
// Takes one execute result per cycle. Non-memory ops retire the following
// cycle. Loads and stores issue one data-memory request and hold the stage
// until the memory acknowledges it.
// Ports:
//   clk, rst_n        - clock; rst_n is a synchronous, active-high reset
//   in_valid/in_ready - handshake with execute; ready only while idle
//   alu_result        - result, or the address for loads and stores
//   store_data        - store value; pc_in / csr_rdata are writeback sources
//   rd_in, rd_wen_in  - destination register and its write enable
//   mem_we, mem_re    - store / load qualifiers
//   wb_sel            - one-hot {MEM,PC,CSR}; zero selects alu_result
//   dmem_*            - request-held-until-ack data-memory port
//   wb_addr/we/data   - register-file write port; wb_we is a one-cycle pulse
//   mem_err           - one-cycle pulse for a misaligned or conflicting access
module mem_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       csr_rdata,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  rd_wen_in,
    input  logic                  mem_we,
    input  logic                  mem_re,
    input  logic [2:0]            wb_sel,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_we,
    output logic [XLEN-1:0]       wb_data,
    output logic                  mem_err
);

    mem_state_e            state_q, state_d;
    logic                  accept;
    logic                  mem_op;
    logic                  bad_access;
    logic                  start_access;
    logic                  access_done;
    logic [XLEN-1:0]       wb_mux;

    // Destination of the load currently waiting for its ack.
    logic [REG_ADDR_W-1:0] pend_rd;
    logic                  pend_wen;
    logic                  pend_load;

    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        accept       = in_valid && in_ready;
        mem_op       = mem_re || mem_we;
        // Both load and store at once is malformed; report it like a misalignment.
        bad_access   = (alu_result[1:0] != 2'b00) || (mem_re && mem_we);
        start_access = accept && mem_op && !bad_access;
        // An ack while idle has no request to complete and is ignored.
        access_done  = (state_q == ST_ACCESS) && dmem_ack;

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_access) state_d = ST_ACCESS;
            ST_ACCESS: if (dmem_ack)     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Writeback source, highest priority first.
    always_comb begin
        if (wb_sel[WB_SEL_MEM])      wb_mux = dmem_rdata;
        else if (wb_sel[WB_SEL_PC])  wb_mux = pc_in + XLEN'(4);
        else if (wb_sel[WB_SEL_CSR]) wb_mux = csr_rdata;
        else                         wb_mux = alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
            pend_rd    <= '0;
            pend_wen   <= 1'b0;
            pend_load  <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_we   <= 1'b0;
            mem_err <= 1'b0;

            if (accept && mem_op && bad_access) begin
                mem_err <= 1'b1;
            end

            if (accept && !mem_op && rd_wen_in && (rd_in != '0)) begin
                wb_we   <= 1'b1;
                wb_addr <= rd_in;
                wb_data <= wb_mux;
            end

            if (start_access) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_we;
                dmem_addr  <= alu_result;
                dmem_wdata <= store_data;
                pend_rd    <= rd_in;
                pend_wen   <= rd_wen_in;
                pend_load  <= mem_re;
            end

            if (access_done) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                if (pend_load && pend_wen && (pend_rd != '0)) begin
                    wb_we   <= 1'b1;
                    wb_addr <= pend_rd;
                    wb_data <= dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc_in;
    logic [31:0] csr_rdata;
    logic [4:0]  rd_in;
    logic        rd_wen_in;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .store_data (store_data),
        .pc_in      (pc_in),
        .csr_rdata  (csr_rdata),
        .rd_in      (rd_in),
        .rd_wen_in  (rd_wen_in),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .wb_sel     (wb_sel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_addr    (wb_addr),
        .wb_we      (wb_we),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc,
                          input logic [31:0] csr, input logic [4:0] rd, input logic wen,
                          input logic we, input logic re, input logic [2:0] sel);
        alu_result = a;
        store_data = sd;
        pc_in      = pc;
        csr_rdata  = csr;
        rd_in      = rd;
        rd_wen_in  = wen;
        mem_we     = we;
        mem_re     = re;
        wb_sel     = sel;
    endtask

    // Reference: value a non-memory op writes back, by source priority.
    function automatic logic [31:0] ref_wb(input logic [2:0] sel, input logic [31:0] alu,
                                           input logic [31:0] pc, input logic [31:0] csr,
                                           input logic [31:0] rdata);
        if (sel[2]) return rdata;
        if (sel[1]) return pc + 32'd4;
        if (sel[0]) return csr;
        return alu;
    endfunction

    task automatic rand_op();
        logic [31:0] a, sd, pc, csr, rdata_now, rdata_mem;
        logic [4:0]  rd;
        logic        wen, we, re, err, wb_exp;
        logic [2:0]  sel;
        int          kind, waits;
        kind = int'($urandom_range(0, 3));
        a    = $urandom;
        sd   = $urandom;
        pc   = $urandom;
        csr  = $urandom;
        rd   = 5'($urandom);
        wen  = ($urandom_range(0, 3) != 0);
        sel  = 3'($urandom_range(0, 7));
        re   = (kind == 2);
        we   = (kind == 3);
        if (kind >= 2) begin
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) begin re = 1'b1; we = 1'b1; end
        end
        rdata_now = $urandom;
        set_op(a, sd, pc, csr, rd, wen, we, re, sel);
        dmem_rdata = rdata_now;
        dmem_ack   = (kind < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        dmem_ack = 1'b0;
        err = (re || we) && ((a[1:0] != 2'b00) || (re && we));
        if (err) begin
            chk("rnd_err_pulse", 32'(mem_err), 32'd1);
            chk("rnd_err_noreq", 32'(dmem_req), 32'd0);
            chk("rnd_err_nowb", 32'(wb_we), 32'd0);
            chk("rnd_err_ready", 32'(in_ready), 32'd1);
        end else if (re || we) begin
            chk("rnd_req", 32'(dmem_req), 32'd1);
            chk("rnd_req_we", 32'(dmem_we), 32'(we));
            chk("rnd_req_addr", dmem_addr, a);
            if (we) chk("rnd_req_wdata", dmem_wdata, sd);
            chk("rnd_busy", 32'(in_ready), 32'd0);
            waits = int'($urandom_range(0, 3));
            repeat (waits) begin
                tick();
                chk("rnd_req_hold", 32'(dmem_req), 32'd1);
                chk("rnd_addr_hold", dmem_addr, a);
                chk("rnd_nowb_wait", 32'(wb_we), 32'd0);
            end
            rdata_mem  = $urandom;
            dmem_rdata = rdata_mem;
            dmem_ack   = 1'b1;
            tick();
            dmem_ack = 1'b0;
            chk("rnd_req_drop", 32'(dmem_req), 32'd0);
            chk("rnd_ready_back", 32'(in_ready), 32'd1);
            wb_exp = re && wen && (rd != 5'd0);
            chk("rnd_ld_wb_we", 32'(wb_we), 32'(wb_exp));
            if (wb_exp) begin
                chk("rnd_ld_wb_addr", 32'(wb_addr), 32'(rd));
                chk("rnd_ld_wb_data", wb_data, rdata_mem);
            end
            chk("rnd_mem_noerr", 32'(mem_err), 32'd0);
        end else begin
            wb_exp = wen && (rd != 5'd0);
            chk("rnd_alu_wb_we", 32'(wb_we), 32'(wb_exp));
            if (wb_exp) begin
                chk("rnd_alu_wb_addr", 32'(wb_addr), 32'(rd));
                chk("rnd_alu_wb_data", wb_data, ref_wb(sel, a, pc, csr, rdata_now));
            end
            chk("rnd_alu_ready", 32'(in_ready), 32'd1);
            chk("rnd_alu_noreq", 32'(dmem_req), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_op('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (2) tick();

        // Reset state
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_dwe", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        rst_n = 1'b0;
        tick();

        // ALU op to x5
        set_op(32'h0000_1234, '0, 32'h40, 32'h77, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("alu_wb_we", 32'(wb_we), 32'd1);
        chk("alu_wb_addr", 32'(wb_addr), 32'd5);
        chk("alu_wb_data", wb_data, 32'h0000_1234);
        tick();
        chk("alu_pulse_end", 32'(wb_we), 32'd0);

        // Back-to-back: CSR to x3 then PC+4 to x4, one per cycle
        set_op(32'h1, '0, 32'h100, 32'hCAFE_0001, 5'd3, 1'b1, 1'b0, 1'b0, 3'b001);
        in_valid = 1'b1;
        tick();
        chk("b2b_csr_data", wb_data, 32'hCAFE_0001);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        set_op(32'h1, '0, 32'h100, 32'hCAFE_0001, 5'd4, 1'b1, 1'b0, 1'b0, 3'b011);
        tick();
        in_valid = 1'b0;
        chk("b2b_pc_we", 32'(wb_we), 32'd1);
        chk("b2b_pc_addr", 32'(wb_addr), 32'd4);
        chk("b2b_pc_data", wb_data, 32'h104);

        // Write to x0 never pulses wb_we
        set_op(32'h55, '0, '0, '0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("x0_no_wb", 32'(wb_we), 32'd0);

        // Load 0x100 to x7, ack after 3 wait cycles
        set_op(32'h100, '0, '0, '0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ld_req", 32'(dmem_req), 32'd1);
        chk("ld_dwe", 32'(dmem_we), 32'd0);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_busy", 32'(in_ready), 32'd0);
        repeat (3) begin
            tick();
            chk("ld_req_hold", 32'(dmem_req), 32'd1);
            chk("ld_addr_hold", dmem_addr, 32'h100);
            chk("ld_busy_hold", 32'(in_ready), 32'd0);
        end
        dmem_rdata = 32'hDEAD_BEEF;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        chk("ld_wb_we", 32'(wb_we), 32'd1);
        chk("ld_wb_addr", 32'(wb_addr), 32'd7);
        chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("ld_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("ld_pulse_end", 32'(wb_we), 32'd0);

        // Store 0x200 with immediate ack
        set_op(32'h200, 32'hA5A5_A5A5, '0, '0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_dwe", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("st_busy", 32'(in_ready), 32'd0);
        chk("st_no_wb_a", 32'(wb_we), 32'd0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("st_dwe_drop", 32'(dmem_we), 32'd0);
        chk("st_req_drop", 32'(dmem_req), 32'd0);
        chk("st_no_wb_b", 32'(wb_we), 32'd0);
        chk("st_ready", 32'(in_ready), 32'd1);

        // Misaligned load
        set_op(32'h102, '0, '0, '0, 5'd8, 1'b1, 1'b0, 1'b1, 3'b100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mis_err", 32'(mem_err), 32'd1);
        chk("mis_noreq", 32'(dmem_req), 32'd0);
        chk("mis_nowb", 32'(wb_we), 32'd0);
        chk("mis_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mis_err_end", 32'(mem_err), 32'd0);
        chk("mis_noreq2", 32'(dmem_req), 32'd0);

        // Load and store both set
        set_op(32'h300, '0, '0, '0, 5'd8, 1'b1, 1'b1, 1'b1, 3'b100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("both_err", 32'(mem_err), 32'd1);
        chk("both_noreq", 32'(dmem_req), 32'd0);

        // Stray ack while idle
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("stray_ack_nowb", 32'(wb_we), 32'd0);
        chk("stray_ack_ready", 32'(in_ready), 32'd1);

        // Reset during a pending load, then a late ack
        set_op(32'h400, '0, '0, '0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rl_req", 32'(dmem_req), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rl_req_off", 32'(dmem_req), 32'd0);
        chk("rl_ready", 32'(in_ready), 32'd1);
        chk("rl_nowb", 32'(wb_we), 32'd0);
        chk("rl_addr_clr", dmem_addr, 32'd0);
        rst_n      = 1'b0;
        dmem_rdata = 32'h1111_2222;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("rl_late_ack_nowb", 32'(wb_we), 32'd0);
        chk("rl_late_ack_noreq", 32'(dmem_req), 32'd0);

        // jal-style link at the top of the address space wraps
        set_op(32'h8, '0, 32'hFFFF_FFFC, '0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b010);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("jal_we", 32'(wb_we), 32'd1);
        chk("jal_addr", 32'(wb_addr), 32'd1);
        chk("jal_data", wb_data, 32'h0000_0000);

        // Randomized traffic against the reference rules
        for (int i = 0; i < 200; i++) begin
            rand_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
